// File: rtl/ieeedrv_track_shifter.sv
// GCR byte shifter and head positioner for one drive mechanism.
// Latency: one byte per 26..32 ce ticks; buf_din must arrive 1 clk after buf_addr; outputs are registered.
// Backpressure: no ready input. trk_busy or mtr=0 freeze the stream. Optional IEEEDRV_DIRTY_EN adds the dirty/dirty_clr ports.
module ieeedrv_track_shifter #(
  parameter int MAX_HT = 84,
  parameter int BUF_AW = 13
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ce,
  input  logic              mtr,
  input  logic [1:0]        step,
  input  logic [1:0]        spd,
  input  logic              hd,
  input  logic              rw,
  input  logic [7:0]        dat_o,
  input  logic [BUF_AW-1:0] trk_len,
  input  logic              trk_busy,
  output logic [7:0]        dat_i,
  output logic              sync_n,
  output logic              brdy_n,
  output logic [6:0]        half_trk,
  output logic              trk_chg,
  output logic [BUF_AW:0]   buf_addr,
  input  logic [7:0]        buf_din,
  output logic [7:0]        buf_dout,
  output logic              buf_we
`ifdef IEEEDRV_DIRTY_EN
  ,
  output logic              dirty,
  input  logic              dirty_clr
`endif
);

  localparam logic [6:0] LP_MAX_HT = 7'(MAX_HT);
  localparam logic [6:0] LP_HT_RST = 7'd36;

  logic [BUF_AW-1:0] r_pos;
  logic [BUF_AW-1:0] r_wr_pos;
  logic              r_wr_hd;
  logic [4:0]        r_tick;
  logic [4:0]        r_last;
  logic              r_prev_ff;
  logic              r_sync_n;
  logic              r_brdy_n;
  logic              r_we;
  logic [7:0]        r_dat;
  logic [7:0]        r_dout;
  logic [6:0]        r_ht;
  logic              r_trk_chg;
  logic [1:0]        r_step;

  logic              w_run;
  logic              w_cnt;
  logic              w_bnd;
  logic              w_up;
  logic              w_dn;
  logic              w_ht_inc;
  logic              w_ht_dec;
  logic              w_move;
  logic [7:0]        w_byte;
  logic              w_is_ff;
  logic              w_sync;
  logic [BUF_AW:0]   w_pos_inc;
  logic              w_wrap;
  logic [4:0]        w_last;

  // Stream runs only with motor on and the loader idle.
  assign w_run     = mtr & ~trk_busy;
  assign w_cnt     = ce & w_run;
  assign w_bnd     = w_cnt & (r_tick == r_last);
  // Last tick index of a byte: 31, 29, 27, 25 for zones 0..3.
  assign w_last    = 5'd31 - {2'b00, spd, 1'b0};

  // Adjacent stepper phase moves the head; a two-phase jump is ambiguous and ignored.
  assign w_up      = (step == r_step + 2'd1);
  assign w_dn      = (step == r_step - 2'd1);
  assign w_ht_inc  = w_up & (r_ht < LP_MAX_HT);
  assign w_ht_dec  = w_dn & (r_ht != 7'd0);
  assign w_move    = w_ht_inc | w_ht_dec;

  // In write mode the written byte is what the head "sees", so sync tracks it too.
  assign w_byte    = rw ? buf_din : dat_o;
  assign w_is_ff   = (w_byte == 8'hFF);
  assign w_sync    = w_is_ff & r_prev_ff;

  // >= rather than == so a track that shrank under us still wraps.
  assign w_pos_inc = {1'b0, r_pos} + {{BUF_AW{1'b0}}, 1'b1};
  assign w_wrap    = (w_pos_inc >= {1'b0, trk_len});

  // Head stepping, byte timing, read/write stream and sync/byte-ready generation.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_pos     <= '0;
      r_wr_pos  <= '0;
      r_wr_hd   <= 1'b0;
      r_tick    <= 5'd0;
      r_last    <= w_last;
      r_prev_ff <= 1'b0;
      r_sync_n  <= 1'b1;
      r_brdy_n  <= 1'b1;
      r_we      <= 1'b0;
      r_dat     <= 8'hFF;
      r_dout    <= 8'h00;
      r_ht      <= LP_HT_RST;
      r_trk_chg <= 1'b0;
      r_step    <= step;
    end else begin
      r_step    <= step;
      r_trk_chg <= 1'b0;
      r_we      <= 1'b0;
      if (w_move) begin
        // Head moved: restart the new track from its start; any boundary this clk is dropped.
        r_ht      <= w_ht_inc ? r_ht + 7'd1 : r_ht - 7'd1;
        r_trk_chg <= 1'b1;
        r_pos     <= '0;
        r_tick    <= 5'd0;
        r_last    <= w_last;
        r_prev_ff <= 1'b0;
        r_sync_n  <= 1'b1;
        r_brdy_n  <= 1'b1;
      end else if (!w_run) begin
        // Frozen: tick/pos hold, handshake outputs go idle, dat_i keeps the last byte.
        r_sync_n  <= 1'b1;
        r_brdy_n  <= 1'b1;
      end else if (w_bnd) begin
        r_tick    <= 5'd0;
        r_last    <= w_last;
        r_dat     <= w_byte;
        r_prev_ff <= w_is_ff;
        r_sync_n  <= ~w_sync;
        r_brdy_n  <= w_sync;
        r_pos     <= w_wrap ? '0 : w_pos_inc[BUF_AW-1:0];
        if (!rw) begin
          r_we     <= 1'b1;
          r_dout   <= dat_o;
          r_wr_pos <= r_pos;
          r_wr_hd  <= hd;
        end
      end else if (w_cnt) begin
        r_tick <= r_tick + 5'd1;
        // Second ce after the boundary ends the byte-ready pulse.
        if (r_tick == 5'd1) r_brdy_n <= 1'b1;
      end
    end
  end

  // Write strobe addresses the byte position that was current before the advance.
  assign buf_addr = r_we ? {r_wr_hd, r_wr_pos} : {hd, r_pos};
  assign buf_dout = r_dout;
  assign buf_we   = r_we;
  assign dat_i    = r_dat;
  assign sync_n   = r_sync_n;
  assign brdy_n   = r_brdy_n;
  assign half_trk = r_ht;
  assign trk_chg  = r_trk_chg;

`ifdef IEEEDRV_DIRTY_EN
  logic r_dirty;

  // Track-modified flag for the loader; clear has priority over a same-clk write.
  always_ff @(posedge clk_sys) begin
    if (reset)          r_dirty <= 1'b0;
    else if (dirty_clr) r_dirty <= 1'b0;
    else if (r_we)      r_dirty <= 1'b1;
  end

  assign dirty = r_dirty;
`endif

endmodule

// File: tb/tb_ieeedrv_track_shifter.sv
// Directed bench for ieeedrv_track_shifter with a 1-clk-latency RAM model.
// Latency: ce every other clk; outputs are sampled on the falling edge.
// Backpressure: exercised via trk_busy and a stepper move that lands on a byte boundary.
module tb_ieeedrv_track_shifter;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ce;
  logic        mtr;
  logic [1:0]  step;
  logic [1:0]  spd;
  logic        hd;
  logic        rw;
  logic [7:0]  dat_o;
  logic [12:0] trk_len;
  logic        trk_busy;
  logic [7:0]  dat_i;
  logic        sync_n;
  logic        brdy_n;
  logic [6:0]  half_trk;
  logic        trk_chg;
  logic [13:0] buf_addr;
  logic [7:0]  buf_din;
  logic [7:0]  buf_dout;
  logic        buf_we;
`ifdef IEEEDRV_DIRTY_EN
  logic        dirty;
  logic        dirty_clr;
`endif

  logic [7:0]  mem [0:16383];
  int          n_chk  = 0;
  int          n_pass = 0;
  int          we_cnt = 0;
  int          chg_cnt = 0;

  always #5 clk_sys = ~clk_sys;

  ieeedrv_track_shifter #(.MAX_HT(84), .BUF_AW(13)) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .ce       (ce),
    .mtr      (mtr),
    .step     (step),
    .spd      (spd),
    .hd       (hd),
    .rw       (rw),
    .dat_o    (dat_o),
    .trk_len  (trk_len),
    .trk_busy (trk_busy),
    .dat_i    (dat_i),
    .sync_n   (sync_n),
    .brdy_n   (brdy_n),
    .half_trk (half_trk),
    .trk_chg  (trk_chg),
    .buf_addr (buf_addr),
    .buf_din  (buf_din),
    .buf_dout (buf_dout),
    .buf_we   (buf_we)
`ifdef IEEEDRV_DIRTY_EN
    ,
    .dirty    (dirty),
    .dirty_clr(dirty_clr)
`endif
  );

  // Track buffer RAM: registered read, write on strobe.
  always @(posedge clk_sys) begin
    buf_din <= mem[buf_addr];
    if (buf_we) mem[buf_addr] = buf_dout;
  end

  // Event counters for strobe-type outputs.
  always @(posedge clk_sys) begin
    if (buf_we)  we_cnt  <= we_cnt + 1;
    if (trk_chg) chg_cnt <= chg_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic ce_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_sys) ce = 1'b1;
      @(negedge clk_sys) ce = 1'b0;
    end
  endtask

  initial begin
    int base_we;
    int base_chg;
    logic bad;
    reset = 1'b1; ce = 1'b0; mtr = 1'b1; step = 2'd0; spd = 2'd3; hd = 1'b0;
    rw = 1'b1; dat_o = 8'h00; trk_len = 13'd100; trk_busy = 1'b0;
`ifdef IEEEDRV_DIRTY_EN
    dirty_clr = 1'b0;
`endif
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    for (int i = 0; i < 100; i++) mem[i] = 8'(i);
    mem[14'h2000] = 8'hFF; mem[14'h2001] = 8'hFF; mem[14'h2002] = 8'hFF; mem[14'h2003] = 8'h52;
    for (int i = 4; i < 100; i++) mem[14'h2000 + i] = 8'(8'h10 + i);

    // Reset state
    repeat (3) @(negedge clk_sys);
    chk("rst_dat_i", 32'(dat_i), 32'hFF);
    chk("rst_sync_n", 32'(sync_n), 32'd1);
    chk("rst_brdy_n", 32'(brdy_n), 32'd1);
    chk("rst_half_trk", 32'(half_trk), 32'd36);
    chk("rst_trk_chg", 32'(trk_chg), 32'd0);
    chk("rst_buf_we", 32'(buf_we), 32'd0);
    chk("rst_buf_addr", 32'(buf_addr), 32'h0);
`ifdef IEEEDRV_DIRTY_EN
    chk("rst_dirty", 32'(dirty), 32'd0);
`endif
    reset = 1'b0;

    // Ramp read at spd 3: first byte on the 26th ce, pulse lasts 2 ce
    ce_n(25);
    chk("pre_first_brdy", 32'(brdy_n), 32'd1);
    ce_n(1);
    chk("first_brdy", 32'(brdy_n), 32'd0);
    chk("first_dat", 32'(dat_i), 32'h00);
    chk("first_addr", 32'(buf_addr), 32'd1);
    ce_n(1);
    chk("brdy_2nd_ce", 32'(brdy_n), 32'd0);
    ce_n(1);
    chk("brdy_end", 32'(brdy_n), 32'd1);
    for (int k = 1; k <= 100; k++) begin
      ce_n((k == 1) ? 24 : 26);
      chk("ramp_dat", 32'(dat_i), 32'(k % 100));
      chk("ramp_brdy", 32'(brdy_n), 32'd0);
      if (k == 99) chk("wrap_addr", 32'(buf_addr), 32'd0);
    end

    // Stepper: 0->1->2 up two half-tracks, 2->0 ignored
    @(negedge clk_sys) begin hd = 1'b1; step = 2'd1; end
    @(negedge clk_sys);
    chk("step1_trk_chg", 32'(trk_chg), 32'd1);
    chk("step1_half", 32'(half_trk), 32'd37);
    chk("step1_addr", 32'(buf_addr), 32'h2000);
    chk("step1_brdy", 32'(brdy_n), 32'd1);
    step = 2'd2;
    @(negedge clk_sys);
    chk("step2_trk_chg", 32'(trk_chg), 32'd1);
    chk("step2_half", 32'(half_trk), 32'd38);
    @(negedge clk_sys);
    chk("step2_pulse_end", 32'(trk_chg), 32'd0);
    step = 2'd0;
    @(negedge clk_sys);
    chk("jump_half", 32'(half_trk), 32'd38);
    chk("jump_trk_chg", 32'(trk_chg), 32'd0);

    // Sync detection: FF FF FF 52
    ce_n(26);
    chk("ff1_dat", 32'(dat_i), 32'hFF);
    chk("ff1_sync", 32'(sync_n), 32'd1);
    chk("ff1_brdy", 32'(brdy_n), 32'd0);
    ce_n(26);
    chk("ff2_sync", 32'(sync_n), 32'd0);
    chk("ff2_brdy", 32'(brdy_n), 32'd1);
    ce_n(26);
    chk("ff3_sync", 32'(sync_n), 32'd0);
    chk("ff3_brdy", 32'(brdy_n), 32'd1);
    ce_n(26);
    chk("b52_dat", 32'(dat_i), 32'h52);
    chk("b52_sync", 32'(sync_n), 32'd1);
    chk("b52_brdy", 32'(brdy_n), 32'd0);

    // Write A5 over three bytes at pos 4,5,6
    base_we = we_cnt;
    rw = 1'b0; dat_o = 8'hA5;
    for (int j = 0; j < 3; j++) begin
      ce_n(26);
      chk("wr_we", 32'(buf_we), 32'd1);
      chk("wr_addr", 32'(buf_addr), 32'(14'h2004 + j));
      chk("wr_dout", 32'(buf_dout), 32'hA5);
      chk("wr_dat_i", 32'(dat_i), 32'hA5);
      chk("wr_brdy", 32'(brdy_n), 32'd0);
    end
    @(negedge clk_sys);
    chk("wr_count", 32'(we_cnt - base_we), 32'd3);
    chk("wr_mem", 32'(mem[14'h2005]), 32'hA5);
`ifdef IEEEDRV_DIRTY_EN
    chk("dirty_set", 32'(dirty), 32'd1);
    dirty_clr = 1'b1;
    @(negedge clk_sys) dirty_clr = 1'b0;
    chk("dirty_clr", 32'(dirty), 32'd0);
`endif
    rw = 1'b1;

    // trk_busy one ce into a byte: pulse cut, 100 ce frozen, resume from same tick
    ce_n(1);
    chk("busy_pre_brdy", 32'(brdy_n), 32'd0);
    trk_busy = 1'b1;
    @(negedge clk_sys);
    chk("busy_brdy_cut", 32'(brdy_n), 32'd1);
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      ce_n(1);
      if (brdy_n !== 1'b1 || buf_addr !== 14'h2007) bad = 1'b1;
    end
    chk("busy_frozen", 32'(bad), 32'd0);
    trk_busy = 1'b0;
    ce_n(24);
    chk("resume_pre", 32'(brdy_n), 32'd1);
    chk("resume_pre_addr", 32'(buf_addr), 32'h2007);
    ce_n(1);
    chk("resume_brdy", 32'(brdy_n), 32'd0);
    chk("resume_dat", 32'(dat_i), 32'h17);

    // Speed change: 32-tick byte, then spd 3 mid-byte only applies to the following byte
    spd = 2'd0;
    ce_n(26);
    chk("spd_b1_dat", 32'(dat_i), 32'h18);
    ce_n(10);
    spd = 2'd3;
    ce_n(21);
    chk("spd32_pre", 32'(brdy_n), 32'd1);
    chk("spd32_pre_addr", 32'(buf_addr), 32'h2009);
    ce_n(1);
    chk("spd32_brdy", 32'(brdy_n), 32'd0);
    chk("spd32_dat", 32'(dat_i), 32'h19);
    ce_n(25);
    chk("spd26_pre", 32'(brdy_n), 32'd1);
    ce_n(1);
    chk("spd26_brdy", 32'(brdy_n), 32'd0);
    chk("spd26_dat", 32'(dat_i), 32'h1A);

    // Boundary coincident with a step: trk_chg wins, no write, pos 0
    base_we = we_cnt;
    ce_n(25);
    rw = 1'b0; dat_o = 8'h5A;
    @(negedge clk_sys) begin ce = 1'b1; step = 2'd1; end
    @(negedge clk_sys) ce = 1'b0;
    chk("coin_trk_chg", 32'(trk_chg), 32'd1);
    chk("coin_half", 32'(half_trk), 32'd39);
    chk("coin_we", 32'(buf_we), 32'd0);
    chk("coin_addr", 32'(buf_addr), 32'h2000);
    chk("coin_brdy", 32'(brdy_n), 32'd1);
    chk("coin_dat", 32'(dat_i), 32'h1A);
    @(negedge clk_sys);
    chk("coin_we_cnt", 32'(we_cnt - base_we), 32'd0);

    // Reset mid-byte
    ce_n(5);
    reset = 1'b1;
    @(negedge clk_sys) reset = 1'b0;
    chk("rst2_half", 32'(half_trk), 32'd36);
    chk("rst2_dat", 32'(dat_i), 32'hFF);
    chk("rst2_addr", 32'(buf_addr), 32'h2000);
    rw = 1'b1;

    // 83 steps down from 36 saturate at 0 with 36 trk_chg pulses
    base_chg = chg_cnt;
    for (int i = 0; i < 83; i++) @(negedge clk_sys) step = step - 2'd1;
    repeat (2) @(negedge clk_sys);
    chk("sat_half", 32'(half_trk), 32'd0);
    chk("sat_chg_cnt", 32'(chg_cnt - base_chg), 32'd36);
    chk("sat_trk_chg", 32'(trk_chg), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
